seq_mux_n: RTL and testbench
============================

Name: seq_mux_n

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; the next generation of the team's combinational 4:1 select mux.
- Adds a clocked output stage, a valid flag and an invalid-select flag.
- Adds an auto-scan mode that steps through the channels on its own, holding each for a programmable dwell time.
- Used wherever several status or data lanes share one downstream consumer (probe or debug bus, shared serialiser input).

Parameters:
- WIDTH, 1: bits per channel.
- NCH, 4: number of channels; 2 ≤ NCH ≤ 2**SEL_W.
- SEL_W, 2: select and channel-index width.
- DWELL, 4: cycles each channel is held in scan mode; DWELL ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NCH*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH].
- sel  in  SEL_W  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan.
- en  in  1  advance/capture enable.
- out_data  out  WIDTH  registered selected channel.
- out_valid  out  1  out_data captured on the previous enabled cycle.
- cur_sel  out  SEL_W  channel index currently driven on out_data.
- sel_err  out  1  last manual capture used sel ≥ NCH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_data = 0, out_valid = 0, cur_sel = 0, sel_err = 0.
  - Dwell counter = 0; state = MANUAL.
- States:
  - MANUAL: entered when mode = 0 at a clock edge.
  - SCAN: entered when mode = 1 at a clock edge; state follows mode with 1-cycle registration.
- en = 0:
  - out_valid <= 0.
  - out_data, cur_sel, sel_err and dwell counter hold.
- MANUAL, en = 1 (latency 1 cycle):
  - If sel < NCH: out_data <= channel[sel], cur_sel <= sel, sel_err <= 0, out_valid <= 1.
  - If sel ≥ NCH: out_data <= 0, cur_sel holds, sel_err <= 1, out_valid <= 1. Never X.
- MANUAL to SCAN transition (edge where mode = 1 and state = MANUAL):
  - cur_sel <= 0, dwell counter <= 0, sel_err <= 0.
  - If en = 1: out_data <= channel[0], out_valid <= 1.
- SCAN, en = 1:
  - out_data <= channel[cur_sel] every cycle, so live data is tracked within the dwell; out_valid <= 1.
  - Dwell counter increments; when it reaches DWELL-1 it clears and cur_sel advances.
  - cur_sel wraps NCH-1 -> 0; it never takes values ≥ NCH.
  - sel is ignored; sel_err stays 0.
- SCAN to MANUAL transition: the manual rule applies on the same edge; dwell counter clears.
- Simultaneous events:
  - mode change with en = 0: state updates; cur_sel/out_data hold until the next en = 1.
  - DWELL = 1: cur_sel advances every enabled cycle.
- Reset mid-scan: all state returns to reset values immediately, with no clock needed. The first enabled cycle after release (mode = 1) captures channel 0.
- Width rules:
  - Dwell counter is wide enough for DWELL-1.
  - Comparisons against NCH use SEL_W+1 bits so that NCH = 2**SEL_W compares correctly.

Optional Feature:
- Macro: SEQ_MUX_N_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit) = even parity (XOR reduction) of the value registered into out_data, updated on the same edge.
  - out_par resets to 0.
  - out_par holds when en = 0.
- Undefined: port out_par and its logic do not exist.

Test Plan:
- Manual sweep (NCH=4, WIDTH=1, in_data=4'b0101, mode=0, en=1; sel=0,1,2,3 one per cycle) -> out_data 1,0,1,0 each one cycle after sel; out_valid=1, sel_err=0, cur_sel follows sel.
- Invalid select (NCH=3, SEL_W=2, sel=3, en=1) -> next cycle out_data=0, sel_err=1, out_valid=1, cur_sel unchanged; then sel=1 -> sel_err=0.
- Scan wrap (NCH=4, DWELL=2, WIDTH=8, channels 8'hA0..8'hA3, mode=1, en=1 for 10 cycles) -> cur_sel 0,0,1,1,2,2,3,3,0,0 and out_data matching A0,A0,A1,...; sel toggled randomly has no effect.
- Enable gating (scan at cur_sel=2 mid-dwell, en=0 for 3 cycles) -> out_valid=0, out_data/cur_sel frozen; on en=1, dwell resumes from its frozen count.
- Async reset mid-scan (assert rst_n low between clock edges with cur_sel=3) -> all outputs 0 immediately; after release with mode=1, en=1 -> first capture is channel 0.
- Parity (with SEQ_MUX_N_PARITY_EN, WIDTH=8, selected 8'h07) -> out_par=1; selected 8'h03 -> out_par=0; without the macro, the bench compiles with no out_par.

Source files
------------

// File: rtl/seq_mux_n.sv
// seq_mux_n: registered N-channel, WIDTH-bit multiplexer with manual select
// and an auto-scan mode that holds each channel for DWELL enabled cycles.
// Optional: define SEQ_MUX_N_PARITY_EN to add out_par, the XOR reduction of
// the value registered into out_data.
module seq_mux_n #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  input  logic                   en,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   sel_err
`ifdef SEQ_MUX_N_PARITY_EN
  ,
  output logic                   out_par
`endif
);

  // Dwell counter only has to reach DWELL-1; keep at least one bit.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  // One extra bit so NCH = 2**SEL_W still compares correctly.
  localparam int SW1 = SEL_W + 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NCH - 1);
  localparam logic [SEL_W:0]   NCH_EXT    = SW1'(NCH);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   out_data_reg, out_data_next;
  logic               out_valid_reg, out_valid_next;
  logic [SEL_W-1:0]   cur_sel_reg, cur_sel_next;
  logic               sel_err_reg, sel_err_next;
  logic [CNT_W-1:0]   dwell_reg, dwell_next;

  logic [WIDTH-1:0]   chan [NCH];
  logic [WIDTH-1:0]   man_pick;
  logic [WIDTH-1:0]   scan_pick;
  logic [SEL_W-1:0]   scan_sel;
  logic [SEL_W-1:0]   next_ch;
  logic               dwell_wrap;
  logic               sel_ok;

  // Unpack the channel bus into an indexable array.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign sel_ok     = ({1'b0, sel} < NCH_EXT);
  assign dwell_wrap = (dwell_reg == DWELL_LAST);
  assign next_ch    = (cur_sel_reg == LAST_CH) ? '0 : cur_sel_reg + SEL_W'(1);
  // Channel that scan mode will drive after this edge; entering scan
  // always restarts at channel 0.
  assign scan_sel   = (state_reg == MANUAL) ? '0
                    : (dwell_wrap ? next_ch : cur_sel_reg);

  // Explicit compare-based muxes: out-of-range selects yield 0, never X.
  always_comb begin
    man_pick  = '0;
    scan_pick = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SEL_W'(k))      man_pick  = chan[k];
      if (scan_sel == SEL_W'(k)) scan_pick = chan[k];
    end
  end

  // Next-state and output-register logic for manual and scan operation.
  always_comb begin
    state_next     = mode ? SCAN : MANUAL;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    cur_sel_next   = cur_sel_reg;
    sel_err_next   = sel_err_reg;
    dwell_next     = dwell_reg;

    if (mode) begin
      // Scan entry and stepping both only happen on enabled cycles; a mode
      // change with en = 0 just moves the state and holds everything else.
      if (en) begin
        out_data_next  = scan_pick;
        out_valid_next = 1'b1;
        cur_sel_next   = scan_sel;
        sel_err_next   = 1'b0;
        if (state_reg == MANUAL || dwell_wrap) begin
          dwell_next = '0;
        end else begin
          dwell_next = dwell_reg + CNT_W'(1);
        end
      end
    end else begin
      if (state_reg == SCAN) begin
        dwell_next = '0;
      end
      if (en) begin
        out_valid_next = 1'b1;
        if (sel_ok) begin
          out_data_next = man_pick;
          cur_sel_next  = sel;
          sel_err_next  = 1'b0;
        end else begin
          out_data_next = '0;
          sel_err_next  = 1'b1;
        end
      end
    end
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= MANUAL;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      cur_sel_reg   <= '0;
      sel_err_reg   <= 1'b0;
      dwell_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      cur_sel_reg   <= cur_sel_next;
      sel_err_reg   <= sel_err_next;
      dwell_reg     <= dwell_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign cur_sel   = cur_sel_reg;
  assign sel_err   = sel_err_reg;

`ifdef SEQ_MUX_N_PARITY_EN
  logic par_reg;

  // Parity tracks out_data; it holds whenever out_data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else begin
      par_reg <= ^out_data_next;
    end
  end

  assign out_par = par_reg;
`endif

endmodule

// File: tb/tb_seq_mux_n.sv
// tb_seq_mux_n: directed bench for seq_mux_n using two instances
// (NCH=4 / DWELL=2 and NCH=3 / DWELL=1, both 8 bits wide).
module tb_seq_mux_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        mode;
  logic        en;
  logic [31:0] d4;
  logic [23:0] d3;

  logic [7:0]  o4, o3;
  logic        v4, v3;
  logic [1:0]  c4, c3;
  logic        e4, e3;
`ifdef SEQ_MUX_N_PARITY_EN
  logic        p4, p3;
`endif

  int tests = 0;
  int fails = 0;

  seq_mux_n #(.WIDTH(8), .NCH(4), .SEL_W(2), .DWELL(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .sel(sel), .mode(mode), .en(en),
    .out_data(o4), .out_valid(v4), .cur_sel(c4), .sel_err(e4)
`ifdef SEQ_MUX_N_PARITY_EN
    , .out_par(p4)
`endif
  );

  seq_mux_n #(.WIDTH(8), .NCH(3), .SEL_W(2), .DWELL(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .sel(sel), .mode(mode), .en(en),
    .out_data(o3), .out_valid(v3), .cur_sel(c3), .sel_err(e3)
`ifdef SEQ_MUX_N_PARITY_EN
    , .out_par(p3)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; en = 1'b0; sel = 2'd0;
    d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    d3 = {8'h30, 8'h20, 8'h10};
    tick();
    en = 1'b1;
    tick();
    tests++; if (o4 !== 8'h00) begin fails++; $display("FAIL reset_out4: got %h expected 00", o4); end
    tests++; if (v4 !== 1'b0) begin fails++; $display("FAIL reset_valid4: got %b expected 0", v4); end
    tests++; if (c4 !== 2'd0) begin fails++; $display("FAIL reset_cur4: got %0d expected 0", c4); end
    tests++; if (e4 !== 1'b0) begin fails++; $display("FAIL reset_err4: got %b expected 0", e4); end
    tests++; if (o3 !== 8'h00 || v3 !== 1'b0) begin fails++; $display("FAIL reset_dut3: got out=%h valid=%b expected 00/0", o3, v3); end
`ifdef SEQ_MUX_N_PARITY_EN
    tests++; if (p4 !== 1'b0) begin fails++; $display("FAIL reset_par4: got %b expected 0", p4); end
`endif
    $display("[TB] reset: out4=%h valid4=%b cur4=%0d err4=%b", o4, v4, c4, e4);
    rst_n = 1'b1;
    en = 1'b0;
    tick();
    tests++; if (v4 !== 1'b0) begin fails++; $display("FAIL idle_valid4: got %b expected 0", v4); end
  endtask

  task automatic test_manual_sweep();
    logic [7:0] exp_out [4];
    exp_out = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    mode = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      tick();
      $display("[TB] manual sel=%0d: out4=%h cur4=%0d valid4=%b err4=%b", k, o4, c4, v4, e4);
      tests++; if (o4 !== exp_out[k]) begin fails++; $display("FAIL manual_out[%0d]: got %h expected %h", k, o4, exp_out[k]); end
      tests++; if (c4 !== 2'(k)) begin fails++; $display("FAIL manual_cur[%0d]: got %0d expected %0d", k, c4, k); end
      tests++; if (v4 !== 1'b1 || e4 !== 1'b0) begin fails++; $display("FAIL manual_flags[%0d]: got valid=%b err=%b expected 1/0", k, v4, e4); end
    end
  endtask

  task automatic test_invalid_sel();
    mode = 1'b0; en = 1'b1;
    sel = 2'd2;
    tick();
    tests++; if (o3 !== 8'h30 || c3 !== 2'd2) begin fails++; $display("FAIL inv_pre: got out=%h cur=%0d expected 30/2", o3, c3); end
    sel = 2'd3;
    tick();
    $display("[TB] invalid sel=3: out3=%h cur3=%0d valid3=%b err3=%b", o3, c3, v3, e3);
    tests++; if (o3 !== 8'h00) begin fails++; $display("FAIL inv_out: got %h expected 00", o3); end
    tests++; if (e3 !== 1'b1) begin fails++; $display("FAIL inv_err: got %b expected 1", e3); end
    tests++; if (v3 !== 1'b1) begin fails++; $display("FAIL inv_valid: got %b expected 1", v3); end
    tests++; if (c3 !== 2'd2) begin fails++; $display("FAIL inv_cur_hold: got %0d expected 2", c3); end
    tests++; if (o4 !== 8'hA3 || e4 !== 1'b0) begin fails++; $display("FAIL full_range_sel3: got out=%h err=%b expected A3/0", o4, e4); end
    en = 1'b0; sel = 2'd0;
    tick();
    $display("[TB] en=0 hold: out3=%h valid3=%b err3=%b", o3, v3, e3);
    tests++; if (v3 !== 1'b0) begin fails++; $display("FAIL hold_valid: got %b expected 0", v3); end
    tests++; if (e3 !== 1'b1 || o3 !== 8'h00 || c3 !== 2'd2) begin fails++; $display("FAIL hold_state: got err=%b out=%h cur=%0d expected 1/00/2", e3, o3, c3); end
    en = 1'b1; sel = 2'd1;
    tick();
    tests++; if (e3 !== 1'b0 || o3 !== 8'h20 || c3 !== 2'd1) begin fails++; $display("FAIL inv_recover: got err=%b out=%h cur=%0d expected 0/20/1", e3, o3, c3); end
  endtask

  task automatic test_scan_wrap();
    logic [1:0] exp_c4 [10];
    logic [7:0] exp_o4 [10];
    logic [1:0] exp_c3 [10];
    logic [7:0] exp_o3 [10];
    exp_c4 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    exp_o4 = '{8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'hA0, 8'hA0};
    exp_c3 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    exp_o3 = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, 8'h10};
    mode = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sel = 2'($urandom_range(0, 3));
      tick();
      $display("[TB] scan %0d sel=%0d: cur4=%0d out4=%h cur3=%0d out3=%h", i, sel, c4, o4, c3, o3);
      tests++; if (c4 !== exp_c4[i] || o4 !== exp_o4[i]) begin fails++; $display("FAIL scan4[%0d]: got cur=%0d out=%h expected %0d/%h", i, c4, o4, exp_c4[i], exp_o4[i]); end
      tests++; if (v4 !== 1'b1 || e4 !== 1'b0) begin fails++; $display("FAIL scan4_flags[%0d]: got valid=%b err=%b expected 1/0", i, v4, e4); end
      tests++; if (c3 !== exp_c3[i] || o3 !== exp_o3[i] || e3 !== 1'b0) begin fails++; $display("FAIL scan3_dwell1[%0d]: got cur=%0d out=%h err=%b expected %0d/%h/0", i, c3, o3, e3, exp_c3[i], exp_o3[i]); end
    end
  endtask

  task automatic test_enable_gating();
    logic [1:0] exp_c [4];
    logic [7:0] exp_o [4];
    exp_c = '{2'd1, 2'd1, 2'd2, 2'd2};
    exp_o = '{8'hA1, 8'hA1, 8'hA2, 8'hA2};
    mode = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (c4 !== exp_c[i] || o4 !== exp_o[i]) begin fails++; $display("FAIL gate_pre[%0d]: got cur=%0d out=%h expected %0d/%h", i, c4, o4, exp_c[i], exp_o[i]); end
    end
    d4[23:16] = 8'h5A;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("[TB] gated %0d: cur4=%0d out4=%h valid4=%b", i, c4, o4, v4);
      tests++; if (v4 !== 1'b0 || c4 !== 2'd2 || o4 !== 8'hA2) begin fails++; $display("FAIL gate_freeze[%0d]: got valid=%b cur=%0d out=%h expected 0/2/A2", i, v4, c4, o4); end
    end
    d4[23:16] = 8'hA2;
    en = 1'b1;
    tick();
    tests++; if (c4 !== 2'd3 || o4 !== 8'hA3 || v4 !== 1'b1) begin fails++; $display("FAIL gate_resume: got cur=%0d out=%h valid=%b expected 3/A3/1", c4, o4, v4); end
    d4[31:24] = 8'hC3;
    tick();
    $display("[TB] live track: cur4=%0d out4=%h", c4, o4);
    tests++; if (c4 !== 2'd3 || o4 !== 8'hC3) begin fails++; $display("FAIL live_track: got cur=%0d out=%h expected 3/C3", c4, o4); end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset: out4=%h valid4=%b cur4=%0d err4=%b", o4, v4, c4, e4);
    tests++; if (o4 !== 8'h00 || v4 !== 1'b0 || c4 !== 2'd0 || e4 !== 1'b0) begin fails++; $display("FAIL async_reset4: got out=%h valid=%b cur=%0d err=%b expected 00/0/0/0", o4, v4, c4, e4); end
    tests++; if (o3 !== 8'h00 || v3 !== 1'b0 || c3 !== 2'd0) begin fails++; $display("FAIL async_reset3: got out=%h valid=%b cur=%0d expected 00/0/0", o3, v3, c3); end
    d4[31:24] = 8'hA3;
    mode = 1'b1; en = 1'b1;
    tick();
    tests++; if (v4 !== 1'b0 || o4 !== 8'h00) begin fails++; $display("FAIL reset_held: got valid=%b out=%h expected 0/00", v4, o4); end
    rst_n = 1'b1;
    tick();
    $display("[TB] post reset: cur4=%0d out4=%h valid4=%b", c4, o4, v4);
    tests++; if (c4 !== 2'd0 || o4 !== 8'hA0 || v4 !== 1'b1) begin fails++; $display("FAIL post_reset_first: got cur=%0d out=%h valid=%b expected 0/A0/1", c4, o4, v4); end
    tick();
    tick();
    tests++; if (c4 !== 2'd1 || o4 !== 8'hA1) begin fails++; $display("FAIL post_reset_step: got cur=%0d out=%h expected 1/A1", c4, o4); end
  endtask

  task automatic test_scan_to_manual();
    mode = 1'b0; en = 1'b1; sel = 2'd2;
    tick();
    $display("[TB] scan->manual sel=2: cur4=%0d out4=%h out3=%h", c4, o4, o3);
    tests++; if (c4 !== 2'd2 || o4 !== 8'hA2 || e4 !== 1'b0 || v4 !== 1'b1) begin fails++; $display("FAIL to_manual4: got cur=%0d out=%h err=%b valid=%b expected 2/A2/0/1", c4, o4, e4, v4); end
    tests++; if (c3 !== 2'd2 || o3 !== 8'h30) begin fails++; $display("FAIL to_manual3: got cur=%0d out=%h expected 2/30", c3, o3); end
  endtask

  task automatic test_parity();
`ifdef SEQ_MUX_N_PARITY_EN
    d4[7:0]  = 8'h07;
    d4[15:8] = 8'h03;
    mode = 1'b0; en = 1'b1;
    sel = 2'd0;
    tick();
    $display("[TB] parity sel=0: out4=%h par4=%b", o4, p4);
    tests++; if (o4 !== 8'h07 || p4 !== 1'b1) begin fails++; $display("FAIL par_07: got out=%h par=%b expected 07/1", o4, p4); end
    sel = 2'd1;
    tick();
    $display("[TB] parity sel=1: out4=%h par4=%b", o4, p4);
    tests++; if (o4 !== 8'h03 || p4 !== 1'b0) begin fails++; $display("FAIL par_03: got out=%h par=%b expected 03/0", o4, p4); end
    sel = 2'd0; en = 1'b0;
    tick();
    tests++; if (p4 !== 1'b0) begin fails++; $display("FAIL par_hold: got %b expected 0", p4); end
`endif
  endtask

  initial begin
    test_reset();
    test_manual_sweep();
    test_invalid_sel();
    test_scan_wrap();
    test_enable_gating();
    test_async_reset();
    test_scan_to_manual();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
